rep5_serial_encoder: RTL and testbench

Transmit side of the majority-vote link. Accepts a parallel data word and sends it serially, MSB first. Each bit is repeated REP times back-to-back so the downstream input_majority voter can recover each bit from any REP-bit window. It sits between the parallel data source and the serial channel, and offers a valid/ready handshake on both sides.

---
 rtl/rep5_serial_encoder.sv | 111 +++++++++++
 tb/tb_rep5_serial_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rep5_serial_encoder.sv
// Repetition-code serial transmitter: sends each bit of a parallel word REP times, MSB first,
// with valid/ready handshakes on both the word side and the symbol side.
module rep5_serial_encoder #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned REP    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic              tx_bit,
   output logic              tx_first,
   output logic              tx_last,
   output logic              busy
);

   localparam int unsigned RepW = (REP > 1) ? $clog2(REP) : 1;
   localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [RepW-1:0] RepMax = RepW'(REP - 1);
   localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
   logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
   logic              accept;
   logic              xfer;

   assign accept = in_valid && in_ready;
   assign xfer   = tx_valid && tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         rep_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         rep_cnt_q <= rep_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      rep_cnt_d = rep_cnt_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StSend;
               shreg_d   = in_data;
               rep_cnt_d = '0;
               bit_cnt_d = '0;
            end
         end
         StSend: begin
            if (xfer) begin
               if (rep_cnt_q != RepMax) begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end else begin
                  rep_cnt_d = '0;
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = (bit_cnt_q == BitMax) ? '0 : bit_cnt_q + 1'b1;
               end
               // Final symbol: either chain straight into the next word or drop to idle.
               if (tx_last) begin
                  if (accept) begin
                     shreg_d = in_data;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      tx_valid = 1'b0;
      tx_bit   = 1'b0;
      tx_first = 1'b0;
      tx_last  = 1'b0;
      busy     = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
         end
         StSend: begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_bit   = shreg_q[DATA_W-1];
            tx_first = (rep_cnt_q == '0) && (bit_cnt_q == '0);
            tx_last  = (rep_cnt_q == RepMax) && (bit_cnt_q == BitMax);
            in_ready = tx_last && tx_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rep5_serial_encoder.sv
// Self-checking bench for rep5_serial_encoder: fixed frame table, corner-case sequences and
// randomized words looped back through a majority voter.
module tb_rep5_serial_encoder;

   localparam int DW  = 8;
   localparam int RP  = 5;
   localparam int FL  = DW * RP;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          tx_ready;
   logic          tx_valid;
   logic          tx_bit;
   logic          tx_first;
   logic          tx_last;
   logic          busy;

   int total = 0;
   int bad   = 0;
   logic cap [FL];

   typedef struct {
      logic [DW-1:0] word;
      logic [FL-1:0] stream;
   } vec_t;

   vec_t vecs [6];

   rep5_serial_encoder #(.DATA_W(DW), .REP(RP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .tx_ready (tx_ready),
      .tx_valid (tx_valid),
      .tx_bit   (tx_bit),
      .tx_first (tx_first),
      .tx_last  (tx_last),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each data bit, MSB first, repeated RP times; index FL-1 is the first symbol.
   function automatic logic [FL-1:0] expand(input logic [DW-1:0] w);
      logic [FL-1:0] s = '0;
      for (int i = DW - 1; i >= 0; i--)
         for (int r = 0; r < RP; r++)
            s = {s[FL-2:0], w[i]};
      return s;
   endfunction

   task automatic start(input logic [DW-1:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tx_ready = 1'b1;
      @(negedge clk);
      chk("start_in_ready", in_ready, 1);
      chk("start_tx_valid", tx_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_check(input string name);
      @(negedge clk);
      chk({name, "_idle_valid"}, tx_valid, 0);
      chk({name, "_idle_ready"}, in_ready, 1);
      chk({name, "_idle_busy"}, busy, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string name, input logic [FL-1:0] exp, input bit chain,
                            input logic [DW-1:0] chain_word, input int stall_at,
                            input int stall_len, input bit noise, input bit rand_rdy);
      int k = 0;
      int cyc = 0;
      int stalled = 0;
      while (k < FL && cyc < 400) begin
         if (rand_rdy) begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end else if (k == stall_at && stalled < stall_len) begin
            tx_ready = 1'b0;
            stalled++;
         end else begin
            tx_ready = 1'b1;
         end
         if (chain && k == FL - 1) begin
            in_valid = 1'b1;
            in_data  = chain_word;
         end else if (noise && k >= 10 && k < 15) begin
            in_valid = 1'b1;
            in_data  = 8'h3C;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk({name, "_valid"}, tx_valid, 1);
         chk({name, "_busy"}, busy, 1);
         chk({name, "_bit"}, tx_bit, exp[FL-1-k]);
         chk({name, "_first"}, tx_first, (k == 0));
         chk({name, "_last"}, tx_last, (k == FL - 1));
         chk({name, "_in_ready"}, in_ready, (k == FL - 1) && tx_ready);
         if (tx_ready) cap[k] = tx_bit;
         @(posedge clk);
         #1;
         if (tx_ready) k++;
         cyc++;
      end
      if (k < FL) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d transfers want %0d", name, k, FL);
      end
      if (stall_len > 0) chk({name, "_cycles"}, cyc, FL + stall_len);
      tx_ready = 1'b1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] w;
      logic [DW-1:0] rec;
      int flip;
      int ones;

      vecs[0] = '{8'hA5, 40'hF83E007C1F};
      vecs[1] = '{8'hFF, 40'hFFFFFFFFFF};
      vecs[2] = '{8'h00, 40'h0000000000};
      vecs[3] = '{8'h80, 40'hF800000000};
      vecs[4] = '{8'h0F, 40'h00000FFFFF};
      vecs[5] = '{8'h3C, 40'h003FFFFC00};

      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      tx_ready = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_bit", tx_bit, 0);
      chk("rst_tx_first", tx_first, 0);
      chk("rst_tx_last", tx_last, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         start(vecs[i].word);
         run_frame($sformatf("vec%0d", i), vecs[i].stream, 0, '0, -1, 0, 0, 0);
         idle_check($sformatf("vec%0d", i));
      end

      // Back-to-back frames with no gap.
      start(8'hFF);
      run_frame("b2b_a", 40'hFFFFFFFFFF, 1, 8'h00, -1, 0, 0, 0);
      run_frame("b2b_b", 40'h0000000000, 0, '0, -1, 0, 0, 0);
      idle_check("b2b");

      // Channel stall after transfer 2.
      start(8'h80);
      run_frame("stall", 40'hF800000000, 0, '0, 2, 3, 0, 0);
      idle_check("stall");

      // Word offered mid-frame must be ignored.
      start(8'hA5);
      run_frame("ignore", 40'hF83E007C1F, 0, '0, -1, 0, 1, 0);
      idle_check("ignore");

      // Reset mid-frame after 12 transfers.
      start(8'hF0);
      repeat (12) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_tx_bit", tx_bit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_check("midrst");
      start(8'h0F);
      run_frame("midrst_new", 40'h00000FFFFF, 0, '0, -1, 0, 0, 0);
      idle_check("midrst_new");

      // Random words, random channel stalls, loopback through a voter with one flip per bit.
      for (int n = 0; n < 20; n++) begin
         w = DW'($urandom);
         start(w);
         run_frame($sformatf("rnd%0d", n), expand(w), 0, '0, -1, 0, 0, 1);
         rec = '0;
         for (int b = 0; b < DW; b++) begin
            flip = $urandom_range(0, RP - 1);
            ones = 0;
            for (int r = 0; r < RP; r++)
               ones += int'(cap[b * RP + r] ^ (r == flip));
            rec = {rec[DW-2:0], (ones > RP / 2)};
         end
         chk($sformatf("loopback%0d", n), rec, w);
         idle_check($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
